mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit.sv | 145 ++++++++++++++
 tb/tb_mul_div_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit: one bit per cycle, 33 cycles from accept to result.
// hi/lo double as the MTHI/MTLO architectural registers.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  // state  | meaning
  // S_IDLE | waiting for start; mthi/mtlo accepted here
  // S_CALC | 32 shift-add / shift-subtract iterations
  // S_FIX  | sign correction and hi/lo write-back
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        dz_q, dz_d;
  logic        neg_lo_q, neg_lo_d;
  logic        neg_hi_q, neg_hi_d;
  logic [31:0] b_q, b_d;
  logic [63:0] p_q, p_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        s1, s2, ge;
  logic [31:0] a_abs, b_abs, rem_n;
  logic [32:0] sum, rem_sh;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    dz_d       = dz_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    b_d        = b_q;
    p_d        = p_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    s1     = op[0] & in1[31];
    s2     = op[0] & in2[31];
    a_abs  = s1 ? -in1 : in1;
    b_abs  = s2 ? -in2 : in2;
    sum    = {1'b0, p_q[63:32]} + {1'b0, b_q};
    // Partial remainder shifted left by one with the next dividend bit pulled in.
    rem_sh = p_q[63:31];
    ge     = rem_sh >= {1'b0, b_q};
    rem_n  = ge ? rem_sh[31:0] - b_q : rem_sh[31:0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CALC;
          cnt_d    = 5'd31;
          is_div_d = op[1];
          dz_d     = (in2 == 32'd0);
          neg_lo_d = s1 ^ s2;
          neg_hi_d = op[1] ? s1 : (s1 ^ s2);
          b_d      = op[1] ? b_abs : a_abs;
          p_d      = op[1] ? {32'd0, a_abs} : {32'd0, b_abs};
        end else begin
          if (mthi) hi_d = in1;
          if (mtlo) lo_d = in1;
        end
      end
      S_CALC: begin
        if (is_div_q)
          p_d = {rem_n, p_q[30:0], ge};
        else
          p_d = p_q[0] ? {sum, p_q[31:1]} : {1'b0, p_q[63:1]};
        if (cnt_q == 5'd0)
          state_d = S_FIX;
        else
          cnt_d = cnt_q - 5'd1;
      end
      S_FIX: begin
        state_d    = S_IDLE;
        done_d     = 1'b1;
        div_zero_d = is_div_q & dz_q;
        // A zero divisor leaves the dividend in the remainder and all ones in the quotient.
        if (is_div_q && dz_q) begin
          hi_d = p_q[63:32];
          lo_d = p_q[31:0];
        end else if (is_div_q) begin
          hi_d = neg_hi_q ? -p_q[63:32] : p_q[63:32];
          lo_d = neg_lo_q ? -p_q[31:0]  : p_q[31:0];
        end else begin
          {hi_d, lo_d} = neg_lo_q ? -p_q : p_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      b_q        <= 32'd0;
      p_q        <= 64'd0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      dz_q       <= dz_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      b_q        <= b_d;
      p_q        <= p_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed products, quotients, latency and control cases.
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] in1 = 32'd0;
  logic [31:0] in2 = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  int          total = 0;
  int          bad = 0;

  localparam logic [1:0] OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op and returns cycles from the start cycle to the done cycle (60 = timed out).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    op = o; in1 = a; in2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; mthi = 1'b1; mtlo = 1'b1; in1 = 32'hDEADBEEF;
    tick(); tick();
    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz: got %b want 0", div_zero); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
  endtask

  task automatic test_multu();
    int cyc, busy_cnt;
    logic held;
    op = OP_MULTU; in1 = 32'hFFFFFFFF; in2 = 32'hFFFFFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; busy_cnt = 0; held = 1'b1;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy === 1'b1) busy_cnt++;
      if (hi !== 32'd0 || lo !== 32'd0) held = 1'b0;
      tick();
      cyc++;
    end
    total++; if (cyc != 34) begin bad++; $display("FAIL multu_latency: got %0d want 34", cyc); end
    total++; if (busy_cnt != 33) begin bad++; $display("FAIL multu_busy_cycles: got %0d want 33", busy_cnt); end
    total++; if (held !== 1'b1) begin bad++; $display("FAIL multu_hold_during_calc: got %b want 1", held); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL multu_busy_at_done: got %b want 0", busy); end
    total++; if (hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    total++; if (lo !== 32'h00000001) begin bad++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_width: got %b want 0", done); end
  endtask

  task automatic test_mult();
    int lat;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'h00000005, lat);
    total++; if (lat != 34) begin bad++; $display("FAIL mult_latency: got %0d want 34", lat); end
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    total++; if (lo !== 32'hFFFFFFF1) begin bad++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL mult_dz: got %b want 0", div_zero); end
    tick();
  endtask

  task automatic test_div();
    int lat;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, lat);
    total++; if (lat != 34) begin bad++; $display("FAIL div_latency: got %0d want 34", lat); end
    total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL div_dz: got %b want 0", div_zero); end
    tick();
    run_op(OP_DIVU, 32'h00000064, 32'h00000000, lat);
    total++; if (lat != 34) begin bad++; $display("FAIL divzero_latency: got %0d want 34", lat); end
    total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL divzero_flag: got %b want 1", div_zero); end
    total++; if (hi !== 32'h00000064) begin bad++; $display("FAIL divzero_hi: got %h want 00000064", hi); end
    total++; if (lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL divzero_lo: got %h want ffffffff", lo); end
    tick();
    run_op(OP_DIVU, 32'h00000064, 32'h00000007, lat);
    total++; if (lo !== 32'h0000000E) begin bad++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
    total++; if (hi !== 32'h00000002) begin bad++; $display("FAIL divu_hi: got %h want 00000002", hi); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL divu_dz_clear: got %b want 0", div_zero); end
    tick();
  endtask

  task automatic test_div_overflow();
    int lat;
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
    total++; if (lo !== 32'h80000000) begin bad++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
    total++; if (hi !== 32'h00000000) begin bad++; $display("FAIL divovf_hi: got %h want 00000000", hi); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL divovf_dz: got %b want 0", div_zero); end
    tick();
    run_op(OP_DIV, 32'h00000007, 32'hFFFFFFFE, lat);
    total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL divneg_lo: got %h want fffffffd", lo); end
    total++; if (hi !== 32'h00000001) begin bad++; $display("FAIL divneg_hi: got %h want 00000001", hi); end
    tick();
  endtask

  task automatic test_mthi_mtlo();
    int cyc;
    in1 = 32'hA5A5A5A5; mthi = 1'b1; mtlo = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    total++; if (hi !== 32'hA5A5A5A5) begin bad++; $display("FAIL mtboth_hi: got %h want a5a5a5a5", hi); end
    total++; if (lo !== 32'hA5A5A5A5) begin bad++; $display("FAIL mtboth_lo: got %h want a5a5a5a5", lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mt_busy: got %b want 0", busy); end
    in1 = 32'h12345678; mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    total++; if (lo !== 32'h12345678) begin bad++; $display("FAIL mtlo_lo: got %h want 12345678", lo); end
    total++; if (hi !== 32'hA5A5A5A5) begin bad++; $display("FAIL mtlo_hi_kept: got %h want a5a5a5a5", hi); end
    op = OP_MULTU; in1 = 32'h00000002; in2 = 32'h00000003; start = 1'b1; mthi = 1'b1;
    tick();
    start = 1'b0; mthi = 1'b0;
    total++; if (hi !== 32'hA5A5A5A5) begin bad++; $display("FAIL start_mthi_dropped: got %h want a5a5a5a5", hi); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy: got %b want 1", busy); end
    cyc = 1;
    repeat (4) begin tick(); cyc++; end
    op = OP_DIVU; in1 = 32'hDEADBEEF; in2 = 32'h00000001; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
    tick();
    cyc++;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    total++; if (hi !== 32'hA5A5A5A5 || lo !== 32'h12345678) begin
      bad++; $display("FAIL midcalc_mt_ignored: got %h_%h want a5a5a5a5_12345678", hi, lo);
    end
    while (done !== 1'b1 && cyc < 60) begin tick(); cyc++; end
    total++; if (cyc != 34) begin bad++; $display("FAIL midcalc_latency: got %0d want 34", cyc); end
    total++; if (hi !== 32'd0 || lo !== 32'h00000006) begin
      bad++; $display("FAIL midcalc_result: got %h_%h want 00000000_00000006", hi, lo);
    end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midcalc_no_queue: got %b want 0", busy); end
  endtask

  task automatic test_abort_reset();
    int cyc;
    logic seen;
    op = OP_MULTU; in1 = 32'hFFFFFFFF; in2 = 32'hFFFFFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin
      bad++; $display("FAIL abort_hilo: got %h_%h want 0_0", hi, lo);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen = 1'b1;
      tick();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done: got %b want 0", seen); end
    run_op(OP_MULTU, 32'h00000003, 32'h00000004, cyc);
    total++; if (cyc != 34) begin bad++; $display("FAIL post_abort_latency: got %0d want 34", cyc); end
    total++; if (lo !== 32'h0000000C || hi !== 32'd0) begin
      bad++; $display("FAIL post_abort_result: got %h_%h want 00000000_0000000c", hi, lo);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(OP_MULTU, 32'h00000007, 32'h00000009, lat);
    total++; if (lo !== 32'h0000003F) begin bad++; $display("FAIL b2b_first_lo: got %h want 0000003f", lo); end
    op = OP_MULT; in1 = 32'hFFFFFFFB; in2 = 32'hFFFFFFFA; start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got %b want 1", busy); end
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin tick(); lat++; end
    total++; if (lat != 34) begin bad++; $display("FAIL b2b_latency: got %0d want 34", lat); end
    total++; if (hi !== 32'd0 || lo !== 32'h0000001E) begin
      bad++; $display("FAIL b2b_result: got %h_%h want 00000000_0000001e", hi, lo);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_overflow();
    test_mthi_mtlo();
    test_abort_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
